apb_mst_arbiter: RTL and testbench

- Shares one APB slave port among NUM_REQ local requesters.
- Arbitrates round-robin and latches the winner's command.
- Drives the APB SETUP/ACCESS sequence and returns PRDATA/PSLVERR to the granted requester.
- Sits between the requesters and the APB slave interface, acting as the bus master.

---
 rtl/apb_mst_arbiter.sv | 134 +++++++++++++
 tb/tb_apb_mst_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_mst_arbiter.sv
// Round-robin arbiter sharing one APB slave port among NUM_REQ requesters; acts as APB master.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_mst_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ-1:0]             req_strb,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_rdata,
    output logic                           resp_slverr,
    output logic                           PSELx,
    output logic                           PENABLE,
    output logic                           PWRITE,
    output logic [ADDR_WIDTH-1:0]          PADDR,
    output logic [DATA_WIDTH-1:0]          PWDATA,
    output logic                           PSTRB,
    input  logic [DATA_WIDTH-1:0]          PRDATA,
    input  logic                           PREADY,
    input  logic                           PSLVERR
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                               state_q, state_d;
    logic [IDX_W-1:0]                     last_q, gnt_q, arb_idx, hi_idx, lo_idx;
    logic [NUM_REQ-1:0]                   outstanding_q, elig;
    logic                                 arb_found, hi_found, done, do_grant, tmo;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_arr;

    assign addr_arr  = req_addr;
    assign wdata_arr = req_wdata;
    assign elig      = req_valid & ~outstanding_q;

    // Lowest eligible index above last wins; otherwise wrap to lowest eligible overall.
    always_comb begin
        hi_found  = 1'b0;
        arb_found = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                arb_found = 1'b1;
                lo_idx    = IDX_W'(i);
                if (IDX_W'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        arb_idx = hi_found ? hi_idx : lo_idx;
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                tcnt_q <= '0;
        else if (state_q != ACCESS)  tcnt_q <= '0;
        else                         tcnt_q <= tcnt_q + TW'(1);
    end

    assign tmo = (state_q == ACCESS) && !PREADY && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
    assign tmo        = 1'b0;
`endif

    assign done     = (state_q == ACCESS) && (PREADY || tmo);
    assign do_grant = arb_found && ((state_q == IDLE) || done);
    assign PSELx    = (state_q != IDLE);
    assign PENABLE  = (state_q == ACCESS);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_found) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (done) state_d = arb_found ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            last_q        <= IDX_W'(NUM_REQ - 1);
            gnt_q         <= '0;
            outstanding_q <= '0;
            req_ack       <= '0;
            resp_valid    <= '0;
            resp_rdata    <= '0;
            resp_slverr   <= 1'b0;
            PWRITE        <= 1'b0;
            PADDR         <= '0;
            PWDATA        <= '0;
            PSTRB         <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_ack    <= '0;
            resp_valid <= '0;
            if (done) begin
                resp_valid[gnt_q]    <= 1'b1;
                resp_rdata           <= tmo ? '0 : PRDATA;
                resp_slverr          <= tmo ? 1'b1 : PSLVERR;
                outstanding_q[gnt_q] <= 1'b0;
            end
            // Completing requester is excluded via outstanding, so arb_idx never equals gnt_q here.
            if (do_grant) begin
                gnt_q                  <= arb_idx;
                last_q                 <= arb_idx;
                outstanding_q[arb_idx] <= 1'b1;
                req_ack[arb_idx]       <= 1'b1;
                PWRITE                 <= req_write[arb_idx];
                PADDR                  <= addr_arr[arb_idx];
                PWDATA                 <= wdata_arr[arb_idx];
                PSTRB                  <= req_strb[arb_idx];
            end
        end
    end

endmodule

// File: tb/tb_apb_mst_arbiter.sv
// Directed self-checking bench for apb_mst_arbiter (4 requesters, 8-bit addr, 32-bit data).
module tb_apb_mst_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic [NR-1:0]     req_valid, req_write, req_strb, req_ack, resp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     resp_rdata, PWDATA, PRDATA;
    logic [AW-1:0]     PADDR;
    logic              resp_slverr, PSELx, PENABLE, PWRITE, PSTRB, PREADY, PSLVERR;

    int nvec = 0;
    int nerr = 0;

    apb_mst_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_ack(req_ack),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_slverr(resp_slverr),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    logic [3:0]  ack_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0]  rv_exp   [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0]  addr_exp [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40};
    logic [31:0] wd_exp   [5] = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000000};
    logic        strb_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_strb = '0;
        req_addr = '0; req_wdata = '0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        do_reset();
        chk("rst_psel",   32'(PSELx), 32'd0);
        chk("rst_pen",    32'(PENABLE), 32'd0);
        chk("rst_ack",    32'(req_ack), 32'd0);
        chk("rst_rv",     32'(resp_valid), 32'd0);
        chk("rst_paddr",  32'(PADDR), 32'd0);
        chk("rst_rdata",  resp_rdata, 32'd0);

        // Single zero-wait read from requester 0.
        req_valid = 4'b0001; req_addr = 32'h00000010; PRDATA = 32'hDEADBEEF;
        tick();
        chk("t1_psel",  32'(PSELx), 32'd1);
        chk("t1_pen0",  32'(PENABLE), 32'd0);
        chk("t1_ack",   32'(req_ack), 32'h1);
        chk("t1_paddr", 32'(PADDR), 32'h10);
        chk("t1_pwr",   32'(PWRITE), 32'd0);
        req_valid = '0;
        tick();
        chk("t1_pen1",  32'(PENABLE), 32'd1);
        chk("t1_rv0",   32'(resp_valid), 32'd0);
        tick();
        chk("t1_rv",    32'(resp_valid), 32'h1);
        chk("t1_rdata", resp_rdata, 32'hDEADBEEF);
        chk("t1_err",   32'(resp_slverr), 32'd0);
        chk("t1_idle",  32'(PSELx), 32'd0);

        // All four write continuously: order 0,1,2,3,0 with no PSELx gap.
        do_reset();
        req_valid = 4'b1111; req_write = 4'b1111; req_strb = 4'b0101;
        req_addr  = 32'h43424140;
        req_wdata = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t2_ack",   32'(req_ack), 32'(ack_exp[n]));
            chk("t2_rv",    32'(resp_valid), 32'(rv_exp[n]));
            chk("t2_paddr", 32'(PADDR), 32'(addr_exp[n]));
            chk("t2_pwd",   PWDATA, wd_exp[n]);
            chk("t2_strb",  32'(PSTRB), 32'(strb_exp[n]));
            chk("t2_pwr",   32'(PWRITE), 32'd1);
            chk("t2_setup", 32'({PSELx, PENABLE}), 32'b10);
            if (n == 4) req_valid = '0;
            tick();
            chk("t2_access", 32'({PSELx, PENABLE}), 32'b11);
        end
        tick();
        chk("t2_rvlast", 32'(resp_valid), 32'h1);
        chk("t2_idle",   32'(PSELx), 32'd0);

        // Write to 0x20 with 3 wait states and a slave error; payload changes after ack.
        req_valid = 4'b0010; req_write = 4'b0010; req_strb = 4'b0010;
        req_addr  = 32'h00002000;
        req_wdata = {32'h0, 32'h0, 32'h12345678, 32'h0};
        PREADY = 1'b0; PRDATA = 32'h55;
        tick();
        chk("t3_ack",   32'(req_ack), 32'h2);
        req_valid = '0; req_addr = 32'h0000FF00; req_wdata = '1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_pen",   32'(PENABLE), 32'd1);
            chk("t3_paddr", 32'(PADDR), 32'h20);
            chk("t3_pwd",   PWDATA, 32'h12345678);
            chk("t3_rv0",   32'(resp_valid), 32'd0);
            if (k == 3) begin PREADY = 1'b1; PSLVERR = 1'b1; end
        end
        tick();
        chk("t3_rv",    32'(resp_valid), 32'h2);
        chk("t3_err",   32'(resp_slverr), 32'd1);
        chk("t3_rdata", resp_rdata, 32'h55);
        chk("t3_idle",  32'(PSELx), 32'd0);
        PSLVERR = 1'b0; req_write = '0;

        // Requester 1 holds request through completion; it may not be regranted in the same cycle.
        req_valid = 4'b0010;
        tick();
        chk("t5_ack1",  32'(req_ack), 32'h2);
        tick();
        chk("t5_pen",   32'(PENABLE), 32'd1);
        tick();
        chk("t5_rv1",   32'(resp_valid), 32'h2);
        chk("t5_gap",   32'(PSELx), 32'd0);
        tick();
        chk("t5_reack", 32'(req_ack), 32'h2);
        req_valid = 4'b1010;
        tick();
        chk("t5_pen2",  32'(PENABLE), 32'd1);
        tick();
        chk("t5_ack3",  32'(req_ack), 32'h8);
        chk("t5_rv1b",  32'(resp_valid), 32'h2);
        chk("t5_b2b",   32'({PSELx, PENABLE}), 32'b10);
        req_valid = '0;
        tick();
        tick();
        chk("t5_rv3",   32'(resp_valid), 32'h8);

        // Reset during ACCESS of requester 2 drops the transfer.
        req_valid = 4'b0100; req_write = 4'b0100; PREADY = 1'b0;
        tick();
        chk("t4_ack2",  32'(req_ack), 32'h4);
        req_valid = '0;
        tick();
        chk("t4_pen",   32'(PENABLE), 32'd1);
        PRESETn = 1'b0;
        #1;
        chk("t4_psel",  32'({PSELx, PENABLE}), 32'd0);
        chk("t4_paddr", 32'(PADDR), 32'd0);
        chk("t4_pwr",   32'(PWRITE), 32'd0);
        chk("t4_rdata", resp_rdata, 32'd0);
        PREADY = 1'b1;
        tick();
        chk("t4_norv",  32'(resp_valid), 32'd0);
        PRESETn = 1'b1;
        req_valid = 4'b1111;
        tick();
        chk("t4_ack0",  32'(req_ack), 32'h1);
        chk("t4_norv2", 32'(resp_valid), 32'd0);
        req_valid = '0;
        tick();
        tick();
        chk("t4_rv0",   32'(resp_valid), 32'h1);

`ifdef APB_ARB_TIMEOUT_EN
        // Stuck slave: forced error completion after 16 ACCESS cycles.
        do_reset();
        req_valid = 4'b0001; req_write = '0; PREADY = 1'b0; PRDATA = 32'hCAFE0000;
        tick();
        req_valid = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("tmo_pen", 32'(PENABLE), 32'd1);
            chk("tmo_rv0", 32'(resp_valid), 32'd0);
        end
        tick();
        chk("tmo_rv",    32'(resp_valid), 32'h1);
        chk("tmo_err",   32'(resp_slverr), 32'd1);
        chk("tmo_rdata", resp_rdata, 32'd0);
        chk("tmo_idle",  32'(PSELx), 32'd0);
        PREADY = 1'b1;
        tick();
        chk("tmo_late",  32'(resp_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
